// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous SRAM port between an instruction-fetch reader (IF) and a data-memory requester (DM)
// DM has priority; a starvation counter forces an IF grant after STARVE_LIMIT consecutive denied IF-request cycles.
// Read data returns one cycle after issue with a registered, reset-gated valid for its owner.
// Ports: clk, rst (sync, active-high); if_req/if_addr -> if_gnt, if_rvalid, if_rdata;
//        dm_req/dm_wen/dm_addr/dm_wdata -> dm_gnt, dm_rvalid, dm_rdata;
//        sram_en/sram_wen/sram_addr/sram_wdata out, sram_rdata in.
// Optional SRAM_ARB_PERF_EN: adds perf_conflict and perf_starve event counters.
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0] perf_conflict,
    output logic [31:0] perf_starve
`endif
);
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       if_rvalid_q, if_rvalid_d;
    logic       dm_rvalid_q, dm_rvalid_d;
    logic       starve;
    always_comb begin
        starve       = starve_cnt_q == 4'(STARVE_LIMIT);
        if_gnt       = !rst && if_req && (!dm_req || starve);
        dm_gnt       = !rst && dm_req && !if_gnt;
        sram_en      = if_gnt || dm_gnt;
        sram_wen     = dm_gnt ? dm_wen : 4'b0;
        sram_addr    = dm_gnt ? dm_addr : if_gnt ? if_addr : 32'b0;
        sram_wdata   = dm_gnt ? dm_wdata : 32'b0;
        starve_cnt_d = (if_gnt || !if_req) ? 4'd0 : starve ? starve_cnt_q : starve_cnt_q + 4'd1;
        if_rvalid_d  = if_gnt;
        dm_rvalid_d  = dm_gnt && (dm_wen == 4'b0);
        // gating by rst drops a response whose read was issued just before reset
        if_rvalid    = if_rvalid_q && !rst;
        dm_rvalid    = dm_rvalid_q && !rst;
        if_rdata     = sram_rdata;
        dm_rdata     = sram_rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            if_rvalid_q  <= 1'b0;
            dm_rvalid_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            dm_rvalid_q  <= dm_rvalid_d;
        end
    end
`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_starve_q, perf_starve_d;
    always_comb begin
        perf_conflict_d = perf_conflict_q + 32'(!rst && if_req && dm_req);
        perf_starve_d   = perf_starve_q + 32'(starve && dm_req && if_gnt);
        perf_conflict   = perf_conflict_q;
        perf_starve     = perf_starve_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_q <= 32'd0;
            perf_starve_q   <= 32'd0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_starve_q   <= perf_starve_d;
        end
    end
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_conflict, perf_starve;
`endif
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
`ifdef SRAM_ARB_PERF_EN
        , .perf_conflict(perf_conflict), .perf_starve(perf_starve)
`endif
    );

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_wen = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        sram_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        if_req = 1'b1; dm_req = 1'b1;
        repeat (3) @(posedge clk);
        next_cycle();
        n_checks++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_if_gnt: got %b exp 0", if_gnt); end
        n_checks++; if (dm_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_dm_gnt: got %b exp 0", dm_gnt); end
        n_checks++; if (sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_sram_en: got %b exp 0", sram_en); end
        n_checks++; if (sram_addr !== 32'h0) begin n_fail++; $display("FAIL reset_sram_addr: got %h exp 0", sram_addr); end
        n_checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b exp 00", {if_rvalid, dm_rvalid}); end
`ifdef SRAM_ARB_PERF_EN
        n_checks++; if (perf_conflict !== 32'd0) begin n_fail++; $display("FAIL reset_perf_conflict: got %0d exp 0", perf_conflict); end
`endif
        drive_idle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_if_alone();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        n_checks++; if ({if_gnt, dm_gnt, sram_en} !== 3'b101) begin n_fail++; $display("FAIL if_alone_gnt: got %b exp 101", {if_gnt, dm_gnt, sram_en}); end
        n_checks++; if (sram_wen !== 4'h0) begin n_fail++; $display("FAIL if_alone_wen: got %h exp 0", sram_wen); end
        n_checks++; if (sram_addr !== 32'h100) begin n_fail++; $display("FAIL if_alone_addr: got %h exp 100", sram_addr); end
        n_checks++; if (sram_wdata !== 32'h0) begin n_fail++; $display("FAIL if_alone_wdata: got %h exp 0", sram_wdata); end
        next_cycle();
        if_req = 1'b0; sram_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (if_rvalid !== 1'b1) begin n_fail++; $display("FAIL if_alone_rvalid: got %b exp 1", if_rvalid); end
        n_checks++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_alone_rdata: got %h exp deadbeef", if_rdata); end
        n_checks++; if (dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL if_alone_dm_rvalid: got %b exp 0", dm_rvalid); end
        n_checks++; if (sram_en !== 1'b0) begin n_fail++; $display("FAIL if_alone_idle_en: got %b exp 0", sram_en); end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_dm_write();
        dm_req = 1'b1; dm_wen = 4'b0100; dm_addr = 32'h202; dm_wdata = 32'h00AB0000;
        #1;
        n_checks++; if ({if_gnt, dm_gnt, sram_en} !== 3'b011) begin n_fail++; $display("FAIL dm_write_gnt: got %b exp 011", {if_gnt, dm_gnt, sram_en}); end
        n_checks++; if (sram_wen !== 4'b0100) begin n_fail++; $display("FAIL dm_write_wen: got %b exp 0100", sram_wen); end
        n_checks++; if (sram_addr !== 32'h202) begin n_fail++; $display("FAIL dm_write_addr: got %h exp 202", sram_addr); end
        n_checks++; if (sram_wdata !== 32'h00AB0000) begin n_fail++; $display("FAIL dm_write_wdata: got %h exp 00ab0000", sram_wdata); end
        next_cycle();
        drive_idle();
        #1;
        n_checks++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin n_fail++; $display("FAIL dm_write_no_rvalid: got %b exp 00", {if_rvalid, dm_rvalid}); end
        next_cycle();
    endtask

    task automatic test_conflict();
        logic prev_if, prev_dm, exp_if;
        prev_if = 1'b0; prev_dm = 1'b0;
        if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_wen = 4'h0; dm_addr = 32'h80;
        #1;
        for (int c = 0; c < 8; c++) begin
            exp_if = (c == 3) || (c == 7);
            n_checks++;
            if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
                n_fail++; $display("FAIL conflict_gnt c%0d: got if/dm %b exp %b", c, {if_gnt, dm_gnt}, {exp_if, !exp_if});
            end
            n_checks++;
            if (sram_addr !== (exp_if ? 32'h40 : 32'h80)) begin
                n_fail++; $display("FAIL conflict_addr c%0d: got %h exp %h", c, sram_addr, exp_if ? 32'h40 : 32'h80);
            end
            n_checks++;
            if ({if_rvalid, dm_rvalid} !== {prev_if, prev_dm}) begin
                n_fail++; $display("FAIL conflict_rvalid c%0d: got %b exp %b", c, {if_rvalid, dm_rvalid}, {prev_if, prev_dm});
            end
            prev_if = exp_if; prev_dm = !exp_if;
            next_cycle();
        end
`ifdef SRAM_ARB_PERF_EN
        n_checks++; if (perf_conflict !== 32'd8) begin n_fail++; $display("FAIL perf_conflict: got %0d exp 8", perf_conflict); end
        n_checks++; if (perf_starve !== 32'd2) begin n_fail++; $display("FAIL perf_starve: got %0d exp 2", perf_starve); end
`endif
        drive_idle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        dm_req = 1'b1; dm_wen = 4'h0; dm_addr = 32'h10;
        #1;
        n_checks++; if ({dm_gnt, sram_addr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL b2b_dm_issue: got %b/%h exp 1/10", dm_gnt, sram_addr); end
        next_cycle();
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h20; sram_rdata = 32'h11111111;
        #1;
        n_checks++; if ({if_gnt, sram_addr} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL b2b_if_issue: got %b/%h exp 1/20", if_gnt, sram_addr); end
        n_checks++; if ({dm_rvalid, if_rvalid} !== 2'b10) begin n_fail++; $display("FAIL b2b_dm_rvalid: got %b exp 10", {dm_rvalid, if_rvalid}); end
        n_checks++; if (dm_rdata !== 32'h11111111) begin n_fail++; $display("FAIL b2b_dm_rdata: got %h exp 11111111", dm_rdata); end
        next_cycle();
        if_req = 1'b0; sram_rdata = 32'h22222222;
        #1;
        n_checks++; if ({dm_rvalid, if_rvalid} !== 2'b01) begin n_fail++; $display("FAIL b2b_if_rvalid: got %b exp 01", {dm_rvalid, if_rvalid}); end
        n_checks++; if (if_rdata !== 32'h22222222) begin n_fail++; $display("FAIL b2b_if_rdata: got %h exp 22222222", if_rdata); end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_reset_mid_read();
        // two denied IF cycles leave the starvation count at 2; cycle N pushes it to 3
        if_req = 1'b1; if_addr = 32'h30; dm_req = 1'b1; dm_wen = 4'h0; dm_addr = 32'h50;
        next_cycle();
        next_cycle();
        n_checks++; if (dm_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_issue: got %b exp 1", dm_gnt); end
        next_cycle();
        rst = 1'b1;
        #1;
        n_checks++; if (dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid_n1: got %b exp 0", dm_rvalid); end
        n_checks++; if ({sram_en, if_gnt, dm_gnt} !== 3'b000) begin n_fail++; $display("FAIL midrst_en: got %b exp 000", {sram_en, if_gnt, dm_gnt}); end
        next_cycle();
        rst = 1'b0;
        #1;
        n_checks++; if (dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid_n2: got %b exp 0", dm_rvalid); end
        n_checks++; if ({if_gnt, dm_gnt} !== 2'b01) begin n_fail++; $display("FAIL midrst_starve_cleared: got if/dm %b exp 01", {if_gnt, dm_gnt}); end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        test_reset();
        test_if_alone();
        test_dm_write();
        test_conflict();
        test_back_to_back();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
